// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions: refill FSM states, the NOP encoding and the
// helpers that split a byte address into offset/word/index/tag fields.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_REFILL = 2'd2,
        ST_RESUME = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    function automatic int word_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits(input int addr_w, input int line_words, input int lines);
        return addr_w - 2 - $clog2(line_words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data store: one refill write port and one synchronous lookup read port.
module icache_data_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache over IF1/IF2 with single-line burst refill.
// Define ICACHE_PERF_CNT_EN to add the perf_hit_cnt/perf_miss_cnt counter ports.
module icache_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int LINES      = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] pc_if1,
    input  logic              stall_if1_if2,
    input  logic              inst_sram_rstn,
    output logic [31:0]       inst_if2,
    output logic              inst_sram_miss,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rlast
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]       perf_hit_cnt,
    output logic [31:0]       perf_miss_cnt
`endif
);

    localparam int WORD_W   = word_bits(LINE_WORDS);
    localparam int IDX_W    = index_bits(LINES);
    localparam int TAG_W    = tag_bits(ADDR_W, LINE_WORDS, LINES);
    localparam int LINE_LSB = 2 + WORD_W;
    localparam int RAM_AW   = IDX_W + WORD_W;

    fetch_state_e      state;
    logic [ADDR_W-1:0] addr_if2;
    logic              v_if2;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [WORD_W-1:0] cnt;
    logic [31:0]       ram_rdata;
    logic [31:0]       inst_hold;
    logic              hit;
    logic              start_refill;
    logic              ram_we;
    logic              fill_done;
    logic [RAM_AW-1:0] ram_raddr;
    logic [RAM_AW-1:0] ram_waddr;
    logic [IDX_W-1:0]  idx_if2;
    logic [TAG_W-1:0]  tag_if2;
    logic [IDX_W-1:0]  idx_fill;
    logic [TAG_W-1:0]  tag_fill;
    logic              unused_bits;

    assign idx_if2  = addr_if2[LINE_LSB +: IDX_W];
    assign tag_if2  = addr_if2[ADDR_W-1 -: TAG_W];
    assign idx_fill = mem_addr[LINE_LSB +: IDX_W];
    assign tag_fill = mem_addr[ADDR_W-1 -: TAG_W];

    assign hit            = v_if2 && valid[idx_if2] && (tags[idx_if2] == tag_if2);
    assign inst_sram_miss = (state != ST_IDLE) || (v_if2 && !hit);
    assign start_refill   = (state == ST_IDLE) && v_if2 && !hit && inst_sram_rstn;
    assign mem_req        = (state == ST_REQ);
    assign ram_we         = (state == ST_REFILL) && mem_rvalid;
    assign fill_done      = ram_we && mem_rlast;

    // Index and word fields sit contiguously above the byte offset, so one slice addresses the RAM.
    assign ram_raddr = stall_if1_if2 ? addr_if2[2 +: RAM_AW] : pc_if1[2 +: RAM_AW];
    assign ram_waddr = {idx_fill, cnt};

    assign inst_if2 = (inst_sram_miss || !v_if2) ? inst_hold : ram_rdata;

    assign unused_bits = ^{pc_if1[1:0], pc_if1[ADDR_W-1:2+RAM_AW], addr_if2[1:0]};

    icache_data_ram #(
        .DEPTH (LINES * LINE_WORDS),
        .AW    (RAM_AW)
    ) u_data_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (mem_rdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // A flush kills the IF2 slot even while the pipeline is stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_if2 <= '0;
            v_if2    <= 1'b0;
        end else begin
            if (!stall_if1_if2) begin
                addr_if2 <= pc_if1;
            end
            if (!inst_sram_rstn) begin
                v_if2 <= 1'b0;
            end else if (!stall_if1_if2) begin
                v_if2 <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            mem_addr <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_refill) begin
                        state    <= ST_REQ;
                        mem_addr <= {addr_if2[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
                    end
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        state <= ST_REFILL;
                        cnt   <= '0;
                    end else if (!inst_sram_rstn) begin
                        state <= ST_IDLE;
                    end
                end
                ST_REFILL: begin
                    if (mem_rvalid) begin
                        cnt <= cnt + WORD_W'(1);
                        if (mem_rlast) begin
                            state <= ST_RESUME;
                        end
                    end
                end
                ST_RESUME: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The line is installed on the last beat even if the beat count came up short.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= '0;
        end else if (fill_done) begin
            valid[idx_fill] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            tags[idx_fill] <= tag_fill;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inst_hold <= NOP_INST;
        end else begin
            inst_hold <= inst_if2;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_hit_cnt  <= '0;
            perf_miss_cnt <= '0;
        end else begin
            if ((state == ST_IDLE) && hit && !stall_if1_if2) begin
                perf_hit_cnt <= perf_hit_cnt + 32'd1;
            end
            if (start_refill) begin
                perf_miss_cnt <= perf_miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped instruction cache spanning the IF1/IF2 fetch stages, directly upstream of the hazard unit.
- Takes the IF1 fetch address and delivers the instruction in IF2.
- On a miss it drives `inst_sram_miss` to the hazard unit and refills one line over a simple burst-read memory port.
- Honours the hazard unit's IF1/IF2 stall and the active-low flush (`inst_sram_rstn`).

Parameters:
- `ADDR_W`, 32, byte address width.
- `LINE_WORDS`, 4, 32-bit words per line (power of 2, ≥2).
- `LINES`, 64, number of lines (power of 2).

Ports:
- `clk`  in  1  system clock
- `rstn`  in  1  asynchronous active-low reset
- `pc_if1`  in  ADDR_W  fetch address in IF1 (word aligned)
- `stall_if1_if2`  in  1  hold the IF2 address register
- `inst_sram_rstn`  in  1  low = flush pending fetch (branch taken in EX)
- `inst_if2`  out  32  instruction for the IF2 address
- `inst_sram_miss`  out  1  IF2 data not valid; pipeline must stall
- `mem_req`  out  1  line read request
- `mem_addr`  out  ADDR_W  line-aligned request address
- `mem_ready`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  refill beat valid
- `mem_rdata`  in  32  refill beat data
- `mem_rlast`  in  1  final beat of the line

Behaviour:
- Reset (asynchronous, `rstn` low):
  - state = IDLE; all valid bits = 0; `v_if2` = 0; beat counter = 0.
  - Outputs: `mem_req` = 0, `mem_addr` = 0, `inst_sram_miss` = 0, `inst_if2` = 32'h00000013 (nop).
- Address split: offset[1:0], word = log2(`LINE_WORDS`) bits, index = log2(`LINES`) bits, tag = remainder.
- Arrays:
  - Tag/valid held in flops.
  - Data held in a synchronous-read RAM.
  - Read index = `stall_if1_if2` ? index(`addr_if2`) : index(`pc_if1`).
- IF2 register:
  - On each clock with `stall_if1_if2`=0: `addr_if2` <= `pc_if1`, `v_if2` <= `inst_sram_rstn`.
  - `inst_sram_rstn`=0 forces `v_if2` <= 0 regardless of stall.
- Hit = `v_if2` & valid[idx] & tag match.
- Hit latency: address in IF1 at cycle N gives instruction in IF2 at cycle N+1, with `inst_sram_miss`=0.
- `inst_sram_miss` = (state==IDLE & `v_if2` & !hit) | (state!=IDLE). It is combinational from state/flops only, not from `pc_if1`.
- FSM:
  - IDLE: on `v_if2` & !hit & `inst_sram_rstn` go to REQ; latch the line-aligned address.
  - REQ: `mem_req`=1 with stable `mem_addr`.
    - `mem_ready` → REFILL.
    - `inst_sram_rstn`=0 before accept → IDLE with no request issued.
    - Accept and flush in the same cycle: accept wins.
  - REFILL: each `mem_rvalid` writes `mem_rdata` to data[idx][cnt], then cnt++.
    - On `mem_rvalid` & `mem_rlast`: write the tag, set valid, go to RESUME.
    - A flush during REFILL does not abort; the line is still installed.
    - `mem_rlast` arriving with cnt≠`LINE_WORDS`-1 is a protocol error; the line is still marked valid (verification flags this as an assertion).
  - RESUME: one cycle re-reading the array at `addr_if2`, then IDLE. The next cycle hits if `v_if2` is still 1.
- Miss penalty (`mem_ready` immediate, one beat per cycle): 1 (detect) + 1 (REQ) + `LINE_WORDS` + 1 (RESUME) cycles with `inst_sram_miss`=1.
- A valid-bit write on the same index as the current lookup takes effect only after RESUME; no bypass.
- `inst_if2` holds its last value while `inst_sram_miss`=1; consumers must ignore it.

Optional Feature:
- Macro: `ICACHE_PERF_CNT_EN`.
- Defined:
  - Adds 32-bit output ports `perf_hit_cnt` and `perf_miss_cnt`, reset to 0.
  - Hit counter increments on each IDLE cycle with `v_if2` & hit & !`stall_if1_if2`.
  - Miss counter increments on each IDLE→REQ transition.
  - Both wrap at 2^32.
- Not defined: no ports and no counter logic.

Decomposition:
- Shared package `cpu_pkg`:
  - FSM state enum (IDLE, REQ, REFILL, RESUME).
  - NOP encoding constant 32'h00000013.
  - Derived widths helper (index, word, tag).
- Sub-module `icache_data_ram`: simple dual-port sync RAM, one write port (refill) and one read port (lookup), depth `LINES`×`LINE_WORDS`, 32-bit.

Test Plan:
- Reset then fetch 0x0000_0000 with memory returning words 0xA0..0xA3 → `inst_sram_miss`=1 for 7 cycles, `mem_addr`=0x0, then `inst_if2`=0xA0. A fetch of 0x4 the next cycle hits with `inst_if2`=0xA1.
- Sequential fetch 0x0,0x4,0x8,0xC after the line is installed → four consecutive hits, `inst_sram_miss`=0, no `mem_req`.
- Miss at 0x100 with `inst_sram_rstn`=0 pulsed while in REQ and `mem_ready`=0 → `mem_req` drops, FSM in IDLE, no refill. A fetch of 0x200 then proceeds normally.
- Flush during REFILL of 0x100 → refill completes and line 0x100 becomes valid; a later fetch of 0x104 hits.
- Conflict: fill 0x0000, then fetch 0x0400 (same index with `LINES`=64) → miss, line replaced; a refetch of 0x0000 misses again.
- `stall_if1_if2`=1 held 3 cycles on a hit while `pc_if1` changes → `inst_if2` stable at the held address's instruction.
